serial_add_arbiter: RTL and testbench

- Shares one bit-serial add cell between two requesters.
- The cell is two halfAdder instances plus an OR for carry-out, with a carry flop.
- Round-robin arbitration picks a requester, captures its operands, steps the cell over WIDTH bits LSB-first, then presents the result with a valid/ready handshake.
- Sits between operand producers and a single result consumer; trades adder area for WIDTH-cycle latency.

---
 rtl/serial_add_arbiter_if.sv | 53 +++++
 rtl/serial_add_arbiter.sv | 139 +++++++++++++
 tb/tb_serial_add_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_arbiter_if.sv
// rtl/serial_add_arbiter_if.sv - requester/result bus for serial_add_arbiter (SERIAL_ADD_SUB_EN adds sub lines)
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             req0_sub;
    logic             req1_sub;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
    logic             busy;

`ifdef SERIAL_ADD_SUB_EN
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        output req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
    );
`else
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
    );
`endif
endinterface

// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - round-robin shared bit-serial adder (SERIAL_ADD_SUB_EN enables subtract)
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               id_q, id_d;

    logic               grant;
    logic               ready0;
    logic               ready1;
    logic               p_bit, g0_bit, s_bit, g1_bit, c_next;
    logic [WIDTH:0]     sum_ext;

    // The shared add cell: two half adders and an OR form one full-adder slice
    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(p_bit), .c(g0_bit));
    half_adder u_ha1 (.a(p_bit),  .b(carry_q), .s(s_bit), .c(g1_bit));
    assign c_next  = g0_bit | g1_bit;
    assign sum_ext = {s_bit, sum_q};

    // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        ready0 = (state_q == IDLE) && !grant && bus.req0_valid;
        ready1 = (state_q == IDLE) &&  grant && bus.req1_valid;
    end

    // Next-state: capture on grant, one sum bit per RUN cycle, hold result until taken
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        id_d         = id_q;
        case (state_q)
            IDLE: begin
                if (ready0 || ready1) begin
                    a_d          = ready1 ? bus.req1_a   : bus.req0_a;
                    b_d          = ready1 ? bus.req1_b   : bus.req0_b;
                    carry_d      = ready1 ? bus.req1_cin : bus.req0_cin;
`ifdef SERIAL_ADD_SUB_EN
                    // Subtract as A + ~B + 1; the requester's cin has no meaning here
                    if (ready1 ? bus.req1_sub : bus.req0_sub) begin
                        b_d     = ready1 ? ~bus.req1_b : ~bus.req0_b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d        = '0;
                    id_d         = ready1;
                    last_grant_d = ready1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = sum_ext[WIDTH:1];
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_sum    = (state_q == DONE) ? sum_q  : '0;
    assign bus.res_cout   = (state_q == DONE) ? cout_q : 1'b0;
    assign bus.res_id     = (state_q == DONE) ? id_q   : 1'b0;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - directed-vector bench with cycle model for serial_add_arbiter
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_arbiter_if #(.WIDTH(W)) bus ();

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 idle, 1 computing (countdown), 2 result held
    int          m_phase = 0;
    int          m_timer = 0;
    logic        m_last  = 1'b1;
    logic [W-1:0] m_sum  = '0;
    logic        m_cout  = 1'b0;
    logic        m_id    = 1'b0;

    function automatic logic exp_rdy0();
        return (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || m_last);
    endfunction

    function automatic logic exp_rdy1();
        return (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || !m_last);
    endfunction

    // Model advances on each rising edge from the same inputs the design sees
    always @(posedge clk) begin
        logic [W:0]   t;
        logic [W-1:0] oa, ob;
        logic         oc, sel;
        if (!rst_n) begin
            m_phase = 0;
            m_last  = 1'b1;
        end else begin
            case (m_phase)
                0: if (exp_rdy0() || exp_rdy1()) begin
                    sel = exp_rdy1();
                    oa  = sel ? bus.req1_a   : bus.req0_a;
                    ob  = sel ? bus.req1_b   : bus.req0_b;
                    oc  = sel ? bus.req1_cin : bus.req0_cin;
`ifdef SERIAL_ADD_SUB_EN
                    if (sel ? bus.req1_sub : bus.req0_sub) begin
                        ob = ~ob;
                        oc = 1'b1;
                    end
`endif
                    t       = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
                    m_sum   = t[W-1:0];
                    m_cout  = t[W];
                    m_id    = sel;
                    m_last  = sel;
                    m_timer = W;
                    m_phase = 1;
                end
                1: begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) m_phase = 2;
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
        end
    end

    task automatic cmp();
        logic [W+5:0] got, exp;
        got = {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_sum,
               bus.res_cout, bus.res_id, bus.busy};
        exp = {exp_rdy0(), exp_rdy1(), m_phase == 2, (m_phase == 2) ? m_sum : {W{1'b0}},
               (m_phase == 2) ? m_cout : 1'b0, (m_phase == 2) ? m_id : 1'b0, m_phase != 0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t got {r0,r1,v,sum,co,id,busy}=%h required %h",
                     $time, got, exp);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit which, input bit v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit cin, input bit sub);
        if (which) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
`ifdef SERIAL_ADD_SUB_EN
            bus.req1_sub = sub;
`endif
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
`ifdef SERIAL_ADD_SUB_EN
            bus.req0_sub = sub;
`endif
        end
        if (sub && !v) bus.res_ready = bus.res_ready;
    endtask

    task automatic do_op(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input bit sub, input logic [W-1:0] es,
                         input bit ec, input int hold);
        int  n;
        bit  acc;
        bus.res_ready = 1'b0;
        set_req(which, 1'b1, a, b, cin, sub);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = which ? bus.req1_ready : bus.req0_ready;
            tick();
        end
        check("accept", {31'd0, acc}, 32'd1);
        set_req(which, 1'b0, '0, '0, 1'b0, 1'b0);
        n = 0;
        while (!bus.res_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, W);
        check("res_sum", {24'd0, bus.res_sum}, {24'd0, es});
        check("res_cout", {31'd0, bus.res_cout}, {31'd0, ec});
        check("res_id", {31'd0, bus.res_id}, {31'd0, which});
        if (hold > 0) set_req(!which, 1'b1, 8'h5A, 8'hA5, 1'b0, 1'b0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold_sum", {24'd0, bus.res_sum}, {24'd0, es});
            check("hold_id", {31'd0, bus.res_id}, {31'd0, which});
            check("hold_readys", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        if (hold > 0) set_req(!which, 1'b0, '0, '0, 1'b0, 1'b0);
        check("idle_after_handshake", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ids[$];
        int   nres;
        bus.res_ready = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        check("reset_outputs", {26'd0, bus.req0_ready, bus.req1_ready, bus.res_valid,
                                bus.res_cout, bus.res_id, bus.busy}, 32'd0);
        check("reset_sum", {24'd0, bus.res_sum}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single operations from each requester
        do_op(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 0);
        do_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 0);

        // Result held while the consumer stalls, other requester pending
        do_op(1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 5);

        // Both requesters always valid from reset, consumer always ready
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        set_req(1'b1, 1'b1, 8'h80, 8'h90, 1'b0, 1'b0);
        for (int c = 0; c < 45; c++) begin
            tick();
            if (bus.res_valid) begin
                ids.push_back(int'(bus.res_id));
                check("rr_sum", {23'd0, bus.res_cout, bus.res_sum},
                      bus.res_id ? 32'h110 : 32'h033);
            end
        end
        check("rr_count", ids.size(), 4);
        for (int i = 0; i < 4 && i < ids.size(); i++) check("rr_order", ids[i], i % 2);
        set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) tick();
        bus.res_ready = 1'b0;

        // Reset while the cell is on bit 3 discards the operation
        set_req(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        #1;
        check("pre_abort_accept", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_idle", {30'd0, bus.busy, bus.res_valid}, 32'd0);
        nres = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.res_valid) nres++;
        end
        check("abort_no_result", nres, 0);
        set_req(1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        set_req(1'b1, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        #1;
        check("abort_first_grant", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd2);
        tick();
        set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        bus.res_ready = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        bus.res_ready = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        do_op(1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 0);
        do_op(1'b1, 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
